keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//  Key-side model of the 3x4 matrix keypad: the opposite end of the scanner's column/row interface.
//  - The scanner drives columns C0..C2. This block returns rows R0..R3 for one commanded key.
//  - It generates press bounce, a steady hold, release bounce and a release gap.
//  - It drives the scanner in closed-loop benches and in on-board self-test, with no physical keypad.
//  - Layout: R0={1,2,3}, R1={4,5,6}, R2={7,8,9}, R3={*,0,#}, columns C0/C1/C2 left to right.
//  - Key codes: 0-9 are the digits, *=10, #=11.
// PARAMETERS
//  BOUNCE_CYC  8      cycles of chatter on press and on release; 0 = clean edges
//  HOLD_CYC    32     cycles of steady closure; must be >=1
//  GAP_CYC     16     cycles of guaranteed open contact after release, before DONE
//  LFSR_SEED   8'hA5  reset/reload value of the bounce LFSR; must be non-zero
// PORTS
//  CLK      in   1  system clock, rising edge
//  RST      in   1  synchronous, active-high reset
//  KEY      in   4  key code, sampled only when PRESS is accepted
//  PRESS    in   1  start pulse for one key press/release sequence
//  C0,C1,C2 in   1  column drives from the scanner
//  R0..R3   out  1  row returns to the scanner
//  CONTACT  out  1  registered switch-closed state, for debug
//  BUSY     out  1  high in every state except IDLE
//  DONE     out  1  one-cycle pulse at the end of a sequence
//  ERR      out  1  one-cycle pulse when PRESS carries KEY>11
// BEHAVIOUR
//  - Reset: state=IDLE, CONTACT=0, BUSY=0, DONE=0, ERR=0, LFSR=LFSR_SEED, counters=0. Hence R0..R3=0.
//  - Row path is combinational from the C inputs, matching a real switch:
//    R[row_q] = CONTACT & C[col_q]; all other rows are 0.
//    The path must settle in the same cycle, because the scanner samples rows while driving all columns.
//  - KEY is decoded to row_q/col_q (2 bits each) on acceptance and held until the sequence ends.
//  - FSM states: IDLE -> BNC_IN -> HOLD -> BNC_OUT -> GAP -> IDLE.
//  - IDLE:
//    - PRESS with KEY<=11: latch row/col. Go to BNC_IN with cnt=BOUNCE_CYC-1, or to HOLD with cnt=HOLD_CYC-1 when BOUNCE_CYC=0.
//    - PRESS with KEY>11: ERR=1 for 1 cycle, stay in IDLE.
//  - BNC_IN: CONTACT<=lfsr[0]; LFSR advances each cycle; at cnt==0 go to HOLD.
//  - HOLD: CONTACT<=1; at cnt==0 go to BNC_OUT, or to GAP when BOUNCE_CYC=0.
//  - BNC_OUT: same as BNC_IN; at cnt==0 go to GAP.
//  - GAP: CONTACT<=0; at cnt==0 go to IDLE with DONE=1 in that same cycle.
//  - Timing: first possible closure is 1 cycle after the PRESS edge. HOLD lasts exactly HOLD_CYC cycles.
//  - Total BUSY time = 2*BOUNCE_CYC+HOLD_CYC+GAP_CYC cycles.
//  - PRESS while BUSY is ignored: not queued, no ERR.
//  - PRESS on the DONE cycle is ignored; it is accepted from the following cycle.
//  - LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances only in BNC_* states and is not reloaded between presses.
//  - Multiple C high at once (scanner "all columns" state) is legal; the row still follows its own column only.
//  - RST mid-sequence: the next edge forces the reset values. CONTACT drops, there is no DONE, and the latched key is discarded.
// STRUCTURE
//  - keypad_defs.vh (shared with the scanner and lock): key-code constants K_0..K_9, K_STAR=10, K_HASH=11, state encodings, row/col lookup.
//  - One sub-module: keypad_bounce_lfsr, with ports CLK, RST, EN, Q[7:0].
//  - Row/column decode and the FSM live in this block.
// TESTING
//  1. Reset held for 3 cycles with C0..C2=1 -> R0..R3=0, BUSY=0, CONTACT=0.
//  2. BOUNCE_CYC=0, KEY=5, PRESS, C1=1 -> R1=1 for exactly 32 cycles starting 1 cycle after PRESS; C0-only or C2-only -> all R=0. DONE arrives 48 cycles after acceptance.
//  3. BOUNCE_CYC=8, KEY=11 (#), C2=1 -> R3 follows the LFSR bit pattern (seed A5) for 8 cycles, steady 1 for 32, chatters for 8, then is 0; BUSY for 64 cycles.
//  4. KEY=13, PRESS -> ERR pulse of 1 cycle, BUSY stays 0, rows stay 0. A PRESS issued in mid-HOLD is ignored and the sequence length is unchanged.
//  5. RST asserted in cycle 10 of HOLD -> CONTACT=0 and rows=0 after the next edge, no DONE; a new PRESS is then accepted normally.
//  6. Closed loop with the scanner, pressing 1..9, 0, *, # -> scanner N equals 1..9, 0, 10, 11, exactly one V pulse per press, and Kd returns to 0 during GAP.

Source files
------------

// File: rtl/keypad_emulator_pkg.sv
// Shared definitions for the keypad emulator: key codes, FSM encodings and key-to-matrix lookup.
package keypad_emulator_pkg;

    localparam int unsigned KEY_W  = 4;
    localparam int unsigned RC_W   = 2;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LFSR_W = 8;

    localparam logic [KEY_W-1:0] K_0    = 4'd0;
    localparam logic [KEY_W-1:0] K_1    = 4'd1;
    localparam logic [KEY_W-1:0] K_2    = 4'd2;
    localparam logic [KEY_W-1:0] K_3    = 4'd3;
    localparam logic [KEY_W-1:0] K_4    = 4'd4;
    localparam logic [KEY_W-1:0] K_5    = 4'd5;
    localparam logic [KEY_W-1:0] K_6    = 4'd6;
    localparam logic [KEY_W-1:0] K_7    = 4'd7;
    localparam logic [KEY_W-1:0] K_8    = 4'd8;
    localparam logic [KEY_W-1:0] K_9    = 4'd9;
    localparam logic [KEY_W-1:0] K_STAR = 4'd10;
    localparam logic [KEY_W-1:0] K_HASH = 4'd11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BNC_IN  = 3'd1;
    localparam logic [2:0] ST_HOLD    = 3'd2;
    localparam logic [2:0] ST_BNC_OUT = 3'd3;
    localparam logic [2:0] ST_GAP     = 3'd4;

    typedef struct packed {
        logic [RC_W-1:0] row;
        logic [RC_W-1:0] col;
    } key_pos_t;

    function automatic logic key_valid(input logic [KEY_W-1:0] key);
        return key <= K_HASH;
    endfunction

    // Matrix position of a key: R0={1,2,3} .. R3={*,0,#}, C0 leftmost.
    function automatic key_pos_t key_to_pos(input logic [KEY_W-1:0] key);
        key_pos_t p;
        p = '0;
        case (key)
            K_1:     p = '{row: 2'd0, col: 2'd0};
            K_2:     p = '{row: 2'd0, col: 2'd1};
            K_3:     p = '{row: 2'd0, col: 2'd2};
            K_4:     p = '{row: 2'd1, col: 2'd0};
            K_5:     p = '{row: 2'd1, col: 2'd1};
            K_6:     p = '{row: 2'd1, col: 2'd2};
            K_7:     p = '{row: 2'd2, col: 2'd0};
            K_8:     p = '{row: 2'd2, col: 2'd1};
            K_9:     p = '{row: 2'd2, col: 2'd2};
            K_STAR:  p = '{row: 2'd3, col: 2'd0};
            K_0:     p = '{row: 2'd3, col: 2'd1};
            K_HASH:  p = '{row: 2'd3, col: 2'd2};
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Column/row and command bundle between a keypad scanner (master) and the emulator (slave).
interface keypad_emulator_if;
    import keypad_emulator_pkg::*;

    logic [KEY_W-1:0] KEY;
    logic             PRESS;
    logic             C0, C1, C2;
    logic             R0, R1, R2, R3;
    logic             CONTACT;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport master (
        output KEY, PRESS, C0, C1, C2,
        input  R0, R1, R2, R3, CONTACT, BUSY, DONE, ERR
    );

    modport slave (
        input  KEY, PRESS, C0, C1, C2,
        output R0, R1, R2, R3, CONTACT, BUSY, DONE, ERR
    );

endinterface

// File: rtl/keypad_bounce_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying contact chatter; advances only when EN is high.
module keypad_bounce_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    output logic [7:0] Q
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= SEED;
        end else if (EN) begin
            Q <= {Q[6:0], Q[7] ^ Q[5] ^ Q[4] ^ Q[3]};
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Key-side model of a 3x4 matrix keypad: plays one commanded key with press bounce, hold,
// release bounce and a release gap, returning rows combinationally from the scanner's columns.
module keypad_emulator
    import keypad_emulator_pkg::*;
#(
    parameter int unsigned BOUNCE_CYC = 8,
    parameter int unsigned HOLD_CYC   = 32,
    parameter int unsigned GAP_CYC    = 16,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic              CLK,
    input  logic              RST,
    keypad_emulator_if.slave  bus
);

    localparam bit               HAS_BNC   = (BOUNCE_CYC != 0);
    localparam logic [CNT_W-1:0] BNC_LOAD  = CNT_W'(BOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic [RC_W-1:0]   col_q, col_d;
    logic              contact_q, contact_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              bnc_d;
    key_pos_t          pos;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-2:0] lfsr_unused;
    logic              col_drive;

    keypad_bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .CLK (CLK),
        .RST (RST),
        .EN  (bnc_d),
        .Q   (lfsr_q)
    );

    // Only bit 0 models the chatter; the upper bits are pure LFSR state.
    assign lfsr_unused = lfsr_q[LFSR_W-1:1];

    // State, latched key and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            contact_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            contact_q <= contact_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next state plus output values derived from the state being entered, so the
    // first closure is visible right after the accepting edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        err_d   = 1'b0;
        pos     = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.PRESS) begin
                    if (key_valid(bus.KEY)) begin
                        pos   = key_to_pos(bus.KEY);
                        row_d = pos.row;
                        col_d = pos.col;
                        if (HAS_BNC) begin
                            state_d = ST_BNC_IN;
                            cnt_d   = BNC_LOAD;
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = HOLD_LOAD;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BNC_IN: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    if (HAS_BNC) begin
                        state_d = ST_BNC_OUT;
                        cnt_d   = BNC_LOAD;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_BNC_OUT: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        bnc_d     = (state_d == ST_BNC_IN) || (state_d == ST_BNC_OUT);
        contact_d = (state_d == ST_HOLD) || (bnc_d && lfsr_q[0]);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_GAP) && (cnt_d == '0);
    end

    // Switch model: only the latched key's column can reach its row.
    always_comb begin
        case (col_q)
            2'd0:    col_drive = bus.C0;
            2'd1:    col_drive = bus.C1;
            2'd2:    col_drive = bus.C2;
            default: col_drive = 1'b0;
        endcase
    end

    assign bus.R0      = contact_q && col_drive && (row_q == 2'd0);
    assign bus.R1      = contact_q && col_drive && (row_q == 2'd1);
    assign bus.R2      = contact_q && col_drive && (row_q == 2'd2);
    assign bus.R3      = contact_q && col_drive && (row_q == 2'd3);
    assign bus.CONTACT = contact_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: one clean-edge instance and one bouncing instance.
module tb_keypad_emulator;

    logic clk;
    logic rst0, rst8;
    int   errors = 0;
    int   checks = 0;

    keypad_emulator_if if0 ();
    keypad_emulator_if if8 ();

    keypad_emulator #(.BOUNCE_CYC(0), .HOLD_CYC(32), .GAP_CYC(16), .LFSR_SEED(8'hA5)) dut0 (
        .CLK (clk), .RST (rst0), .bus (if0.slave));
    keypad_emulator #(.BOUNCE_CYC(8), .HOLD_CYC(32), .GAP_CYC(16), .LFSR_SEED(8'hA5)) dut8 (
        .CLK (clk), .RST (rst8), .bus (if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [2:0] c;
        logic [3:0] r;
        logic       contact;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[9];
    int   keymap[4][3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rows0();
        return {if0.R3, if0.R2, if0.R1, if0.R0};
    endfunction

    function automatic logic [3:0] rows8();
        return {if8.R3, if8.R2, if8.R1, if8.R0};
    endfunction

    task automatic set_c0(input logic [2:0] c);
        {if0.C2, if0.C1, if0.C0} = c;
    endtask

    // Issue PRESS for one edge; returns in the first cycle after the accepting edge.
    task automatic press0(input int key);
        if0.KEY   = 4'(key);
        if0.PRESS = 1'b1;
        step();
        if0.PRESS = 1'b0;
    endtask

    task automatic run_to_idle0(input int budget);
        int n;
        n = 0;
        while (if0.BUSY === 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'd1);
        step();
    endtask

    initial begin
        logic [7:0] lfsr;
        logic       exp_ct;
        int         busy_n, done_k, err_n, done_n, dec, keys[12];
        logic [3:0] rv;

        keymap[0] = '{1, 2, 3};
        keymap[1] = '{4, 5, 6};
        keymap[2] = '{7, 8, 9};
        keymap[3] = '{10, 0, 11};
        keys = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 10, 11};

        tbl[0] = '{k: 0,  c: 3'b010, r: 4'b0010, contact: 1'b1, busy: 1'b1, done: 1'b0};
        tbl[1] = '{k: 5,  c: 3'b001, r: 4'b0000, contact: 1'b1, busy: 1'b1, done: 1'b0};
        tbl[2] = '{k: 10, c: 3'b100, r: 4'b0000, contact: 1'b1, busy: 1'b1, done: 1'b0};
        tbl[3] = '{k: 15, c: 3'b111, r: 4'b0010, contact: 1'b1, busy: 1'b1, done: 1'b0};
        tbl[4] = '{k: 31, c: 3'b010, r: 4'b0010, contact: 1'b1, busy: 1'b1, done: 1'b0};
        tbl[5] = '{k: 32, c: 3'b010, r: 4'b0000, contact: 1'b0, busy: 1'b1, done: 1'b0};
        tbl[6] = '{k: 46, c: 3'b111, r: 4'b0000, contact: 1'b0, busy: 1'b1, done: 1'b0};
        tbl[7] = '{k: 47, c: 3'b111, r: 4'b0000, contact: 1'b0, busy: 1'b1, done: 1'b1};
        tbl[8] = '{k: 48, c: 3'b111, r: 4'b0000, contact: 1'b0, busy: 1'b0, done: 1'b0};

        if0.KEY = '0; if0.PRESS = 1'b0; set_c0(3'b111);
        if8.KEY = '0; if8.PRESS = 1'b0; {if8.C2, if8.C1, if8.C0} = 3'b111;

        // Reset with all columns driven.
        rst0 = 1'b1; rst8 = 1'b1;
        repeat (3) step();
        chk("rst_rows0", 32'(rows0()), 32'd0);
        chk("rst_rows8", 32'(rows8()), 32'd0);
        chk("rst_busy0", 32'(if0.BUSY), 32'd0);
        chk("rst_contact0", 32'(if0.CONTACT), 32'd0);
        chk("rst_busy8", 32'(if8.BUSY), 32'd0);
        chk("rst_contact8", 32'(if8.CONTACT), 32'd0);
        chk("rst_done0", 32'(if0.DONE), 32'd0);
        chk("rst_err0", 32'(if0.ERR), 32'd0);
        rst0 = 1'b0; rst8 = 1'b0;
        step();

        // Clean edges, key 5 (R1/C1), table of column patterns.
        press0(5);
        begin
            int k;
            k = 0;
            for (int i = 0; i < 9; i++) begin
                while (k < tbl[i].k) begin
                    step();
                    k++;
                end
                set_c0(tbl[i].c);
                #1;
                chk($sformatf("t2_rows_k%0d", tbl[i].k), 32'(rows0()), 32'(tbl[i].r));
                chk($sformatf("t2_contact_k%0d", tbl[i].k), 32'(if0.CONTACT), 32'(tbl[i].contact));
                chk($sformatf("t2_busy_k%0d", tbl[i].k), 32'(if0.BUSY), 32'(tbl[i].busy));
                chk($sformatf("t2_done_k%0d", tbl[i].k), 32'(if0.DONE), 32'(tbl[i].done));
            end
        end
        step();

        // Bouncing instance, key # on R3/C2, against a reference LFSR from seed A5.
        {if8.C2, if8.C1, if8.C0} = 3'b100;
        if8.KEY = 4'd11; if8.PRESS = 1'b1;
        step();
        if8.PRESS = 1'b0;
        lfsr = 8'hA5;
        for (int k = 0; k < 66; k++) begin
            if (k < 8 || (k >= 40 && k < 48)) begin
                exp_ct = lfsr[0];
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end else begin
                exp_ct = (k < 40);
            end
            #1;
            chk($sformatf("t3_rows_k%0d", k), 32'(rows8()), 32'({exp_ct, 3'b000}));
            chk($sformatf("t3_busy_k%0d", k), 32'(if8.BUSY), 32'(k < 64));
            chk($sformatf("t3_done_k%0d", k), 32'(if8.DONE), 32'(k == 63));
            step();
        end

        // Out-of-range key: ERR pulse only.
        set_c0(3'b111);
        press0(13);
        chk("t4_err", 32'(if0.ERR), 32'd1);
        chk("t4_err_busy", 32'(if0.BUSY), 32'd0);
        chk("t4_err_rows", 32'(rows0()), 32'd0);
        step();
        chk("t4_err_len", 32'(if0.ERR), 32'd0);

        // PRESS in mid-HOLD is ignored; sequence length unchanged.
        press0(5);
        busy_n = 0; done_k = -1; err_n = 0;
        for (int k = 0; k < 60; k++) begin
            #1;
            if (if0.BUSY === 1'b1) busy_n++;
            if (if0.DONE === 1'b1) done_k = k;
            if (if0.ERR === 1'b1) err_n++;
            if (k == 10) begin
                if0.KEY = 4'd13;
                if0.PRESS = 1'b1;
            end else begin
                if0.PRESS = 1'b0;
            end
            step();
        end
        chk("t4_busy_len", 32'(busy_n), 32'd48);
        chk("t4_done_k", 32'(done_k), 32'd47);
        chk("t4_no_err", 32'(err_n), 32'd0);
        chk("t4_not_queued", 32'(if0.BUSY), 32'd0);

        // PRESS on the DONE cycle is ignored, accepted one cycle later.
        press0(5);
        begin
            int n;
            n = 0;
            while (if0.DONE !== 1'b1 && n < 100) begin
                step();
                n++;
            end
            chk("t4_done_seen", 32'(n < 100), 32'd1);
        end
        if0.KEY = 4'd1; if0.PRESS = 1'b1;
        step();
        chk("t4_press_on_done", 32'(if0.BUSY), 32'd0);
        set_c0(3'b001);
        step();
        if0.PRESS = 1'b0;
        #1;
        chk("t4_press_after_done", 32'(if0.BUSY), 32'd1);
        chk("t4_rows_key1", 32'(rows0()), 32'b0001);
        run_to_idle0(100);

        // Reset in HOLD cycle 10 drops everything, no DONE, then a fresh press works.
        set_c0(3'b010);
        press0(5);
        repeat (10) step();
        chk("t5_pre_rows", 32'(rows0()), 32'b0010);
        rst0 = 1'b1;
        step();
        #1;
        chk("t5_contact", 32'(if0.CONTACT), 32'd0);
        chk("t5_rows", 32'(rows0()), 32'd0);
        chk("t5_busy", 32'(if0.BUSY), 32'd0);
        rst0 = 1'b0;
        done_n = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (if0.DONE === 1'b1) done_n++;
        end
        chk("t5_no_done", 32'(done_n), 32'd0);
        set_c0(3'b001);
        press0(7);
        #1;
        chk("t5_new_rows", 32'(rows0()), 32'b0100);
        chk("t5_new_busy", 32'(if0.BUSY), 32'd1);
        run_to_idle0(100);

        // Mini scanner: scan one column at a time and decode each key.
        for (int i = 0; i < 12; i++) begin
            press0(keys[i]);
            dec = -1;
            for (int c = 0; c < 3; c++) begin
                set_c0(3'(1 << c));
                #1;
                rv = rows0();
                for (int r = 0; r < 4; r++) begin
                    if (rv[r]) dec = keymap[r][c];
                end
            end
            chk($sformatf("t6_decode_%0d", keys[i]), 32'(dec), 32'(keys[i]));
            set_c0(3'b111);
            done_n = 0;
            for (int k = 0; k < 60; k++) begin
                step();
                if (if0.DONE === 1'b1) begin
                    done_n++;
                    chk($sformatf("t6_gap_rows_%0d", keys[i]), 32'(rows0()), 32'd0);
                end
            end
            chk($sformatf("t6_done_cnt_%0d", keys[i]), 32'(done_n), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
